pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Central stall/flush controller of the 5-stage pipeline; drives stall and enable into the PC and the pipe regs.
//  Combines load-use hazard detection, ID-stage branch/jump flush and multi-cycle data-memory wait into one
//  FSM, plus a memory-wait watchdog that halts fetch on a hung dcache. Sits beside the ID stage.
// PARAMETERS
//  REG_AW       5    register-specifier width
//  MEM_TIMEOUT  255  MEM_WAIT cycles before watchdog trips (>=1)
//  CNT_W        32   perf-counter width (used only with STALL_PERF_CNT_EN)
// PORTS
//  clk_i            in   1       clock
//  rst_i            in   1       reset, asynchronous, active-low
//  start_i          in   1       core run enable
//  id_ex_memread_i  in   1       instruction in EX is a load
//  id_ex_rt_i       in   REG_AW  load destination register
//  if_id_rs_i       in   REG_AW  ID-stage source rs
//  if_id_rt_i       in   REG_AW  ID-stage source rt
//  branch_taken_i   in   1       branch resolved taken in ID
//  jump_i           in   1       jump decoded in ID
//  mem_req_i        in   1       MEM stage issuing dcache access
//  mem_ack_i        in   1       dcache access complete
//  pc_stall_o       out  1       hold PC (load-use or freeze)
//  pc_enable_o      out  1       PC update permitted (0 in IDLE/HALT)
//  if_id_write_o    out  1       IF/ID register write enable
//  if_id_flush_o    out  1       zero IF/ID (taken branch/jump)
//  id_ex_bubble_o   out  1       insert NOP into ID/EX
//  pipe_freeze_o    out  1       freeze all pipeline regs
//  mem_timeout_o    out  1       sticky watchdog flag
//  lu_cnt_o / mem_cnt_o / flush_cnt_o  out  CNT_W each  perf counters
// BEHAVIOUR
//  - Reset: state IDLE, timeout and counters 0; every output 0. Control outputs are combinational from state+inputs.
//  - IDLE: pc_enable_o=0, if_id_write_o=0, all else 0. start_i=1 -> RUN next cycle.
//  - RUN defaults: pc_enable_o=1, if_id_write_o=1, others 0. Priority freeze > load-use > flush:
//    * freeze: mem_req_i & ~mem_ack_i -> pipe_freeze_o=1, pc_stall_o=1, if_id_write_o=0, no bubble/flush; -> MEM_WAIT.
//      mem_req_i & mem_ack_i same cycle: no stall, stay RUN.
//    * load-use: id_ex_memread_i & id_ex_rt_i!=0 & (id_ex_rt_i==if_id_rs_i | id_ex_rt_i==if_id_rt_i)
//      -> pc_stall_o=1, if_id_write_o=0, id_ex_bubble_o=1 same cycle (zero latency); one-cycle event, no state.
//    * flush: (branch_taken_i|jump_i) and no load-use -> if_id_flush_o=1. Load-use + branch same cycle:
//      flush suppressed, branch re-resolved next cycle.
//    * start_i=0 with no freeze -> IDLE next cycle.
//  - MEM_WAIT: pipe_freeze_o=1, pc_stall_o=1, if_id_write_o=0 while ~mem_ack_i; wait counter increments.
//    mem_ack_i=1: freeze outputs 0 that cycle, -> RUN (start_i ignored until exit). Counter clears on exit.
//    Counter reaches MEM_TIMEOUT with no ack -> mem_timeout_o=1 (registered), -> HALT.
//  - HALT: pc_enable_o=0, pipe_freeze_o=1, if_id_write_o=0; leaves only by rst_i. mem_timeout_o sticky.
//  - Async reset mid-MEM_WAIT: immediately IDLE, counter and flag cleared.
// CONFIGURATION
//  STALL_PERF_CNT_EN defined: lu_cnt_o counts load-use cycles, mem_cnt_o freeze cycles (RUN entry + MEM_WAIT),
//    flush_cnt_o flush cycles; each saturates at all-ones, resets to 0.
//  Undefined: counter logic omitted, the three ports kept and tied to 0.
// STRUCTURE
//  Package pipeline_ctrl_pkg: typedef ctrl_state_t {IDLE=2'd0, RUN=2'd1, MEM_WAIT=2'd2, HALT=2'd3}; REG_ZERO constant.
//  Sub-module hazard_detect: combinational load-use compare (memread, rt, rs, rt in -> hazard out).
//  FSM, watchdog and counters stay in the top.
// TESTING
//  1 rst_i=0 then 1, start_i=0 -> all outputs 0; start_i=1 -> RUN next cycle, pc_enable_o=1, if_id_write_o=1.
//  2 memread=1, id_ex_rt=5, if_id_rs=5 -> same cycle pc_stall=1, if_id_write=0, bubble=1; id_ex_rt=0 -> no stall.
//  3 load-use hazard + branch_taken=1 same cycle -> flush=0, bubble=1; next cycle (no hazard) branch -> flush=1.
//  4 mem_req=1, ack at 4th cycle -> freeze=1 for 3 cycles, 0 in ack cycle, RUN after; req+ack same cycle -> no freeze.
//  5 MEM_TIMEOUT=8, no ack -> mem_timeout_o=1 after 8 wait cycles, HALT, pc_enable_o=0 until rst_i pulse clears it.
//  6 STALL_PERF_CNT_EN, CNT_W=2: 5 load-use cycles -> lu_cnt_o saturates at 3; without macro, all counters 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// Holds the controller state encoding and the hard-wired zero register index.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      HALT     = 2'd3
   } ctrl_state_t;

   // Register 0 reads as zero, so a load into it never creates a real dependency.
   localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source operands in ID.
// Purely combinational; the result is used in the same cycle.
module hazard_detect
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              memread,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   output logic              hazard
);

   assign hazard = memread && (ex_rt != REG_AW'(REG_ZERO)) &&
                   ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller: load-use bubble, ID flush, dcache wait freeze and hang watchdog.
// Optional perf counters are built when STALL_PERF_CNT_EN is defined; otherwise they read 0.
module pipeline_stall_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              id_ex_memread_i,
   input  logic [REG_AW-1:0] id_ex_rt_i,
   input  logic [REG_AW-1:0] if_id_rs_i,
   input  logic [REG_AW-1:0] if_id_rt_i,
   input  logic              branch_taken_i,
   input  logic              jump_i,
   input  logic              mem_req_i,
   input  logic              mem_ack_i,
   output logic              pc_stall_o,
   output logic              pc_enable_o,
   output logic              if_id_write_o,
   output logic              if_id_flush_o,
   output logic              id_ex_bubble_o,
   output logic              pipe_freeze_o,
   output logic              mem_timeout_o,
   output logic [CNT_W-1:0]  lu_cnt_o,
   output logic [CNT_W-1:0]  mem_cnt_o,
   output logic [CNT_W-1:0]  flush_cnt_o
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   ctrl_state_t       state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              load_use;
   logic              trip;

   hazard_detect #(.REG_AW(REG_AW)) u_hazard (
      .memread (id_ex_memread_i),
      .ex_rt   (id_ex_rt_i),
      .id_rs   (if_id_rs_i),
      .id_rt   (if_id_rt_i),
      .hazard  (load_use)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         mem_timeout_o <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == MEM_WAIT && !mem_ack_i && !trip)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if (trip)
            mem_timeout_o <= 1'b1;
      end
   end

   always_comb begin
      state_nxt      = state;
      trip           = 1'b0;
      pc_stall_o     = 1'b0;
      pc_enable_o    = 1'b0;
      if_id_write_o  = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      pipe_freeze_o  = 1'b0;
      case (state)
         IDLE: begin
            if (start_i)
               state_nxt = RUN;
         end
         RUN: begin
            pc_enable_o   = 1'b1;
            if_id_write_o = 1'b1;
            if (mem_req_i && !mem_ack_i) begin
               pipe_freeze_o = 1'b1;
               pc_stall_o    = 1'b1;
               if_id_write_o = 1'b0;
               state_nxt     = MEM_WAIT;
            end else begin
               // A load-use stall wins over a flush; the branch re-resolves next cycle.
               if (load_use) begin
                  pc_stall_o     = 1'b1;
                  if_id_write_o  = 1'b0;
                  id_ex_bubble_o = 1'b1;
               end else if (branch_taken_i || jump_i) begin
                  if_id_flush_o = 1'b1;
               end
               if (!start_i)
                  state_nxt = IDLE;
            end
         end
         MEM_WAIT: begin
            pc_enable_o = 1'b1;
            if (mem_ack_i) begin
               if_id_write_o = 1'b1;
               state_nxt     = RUN;
            end else begin
               pipe_freeze_o = 1'b1;
               pc_stall_o    = 1'b1;
               if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                  trip      = 1'b1;
                  state_nxt = HALT;
               end
            end
         end
         HALT: begin
            pipe_freeze_o = 1'b1;
            pc_stall_o    = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef STALL_PERF_CNT_EN
   logic lu_evt, mem_evt, flush_evt;

   assign lu_evt    = id_ex_bubble_o;
   assign mem_evt   = pipe_freeze_o && (state != HALT);
   assign flush_evt = if_id_flush_o;

   // Counters saturate rather than wrap so long runs never under-report.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         lu_cnt_o    <= '0;
         mem_cnt_o   <= '0;
         flush_cnt_o <= '0;
      end else begin
         if (lu_evt && (lu_cnt_o != '1))
            lu_cnt_o <= lu_cnt_o + 1'b1;
         if (mem_evt && (mem_cnt_o != '1))
            mem_cnt_o <= mem_cnt_o + 1'b1;
         if (flush_evt && (flush_cnt_o != '1))
            flush_cnt_o <= flush_cnt_o + 1'b1;
      end
   end
`else
   assign lu_cnt_o    = '0;
   assign mem_cnt_o   = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: driver pushes model predictions, monitor compares at negedge.
module tb_pipeline_stall_ctrl;

   localparam int AW = 5;
   localparam int TO = 8;
   localparam int CW = 2;
   localparam int OW = 7 + 3 * CW;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic          id_ex_memread_i;
   logic [AW-1:0] id_ex_rt_i, if_id_rs_i, if_id_rt_i;
   logic          branch_taken_i, jump_i, mem_req_i, mem_ack_i;
   logic          pc_stall_o, pc_enable_o, if_id_write_o, if_id_flush_o;
   logic          id_ex_bubble_o, pipe_freeze_o, mem_timeout_o;
   logic [CW-1:0] lu_cnt_o, mem_cnt_o, flush_cnt_o;

   pipeline_stall_ctrl #(.REG_AW(AW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .id_ex_memread_i(id_ex_memread_i), .id_ex_rt_i(id_ex_rt_i),
      .if_id_rs_i(if_id_rs_i), .if_id_rt_i(if_id_rt_i),
      .branch_taken_i(branch_taken_i), .jump_i(jump_i),
      .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
      .pc_stall_o(pc_stall_o), .pc_enable_o(pc_enable_o),
      .if_id_write_o(if_id_write_o), .if_id_flush_o(if_id_flush_o),
      .id_ex_bubble_o(id_ex_bubble_o), .pipe_freeze_o(pipe_freeze_o),
      .mem_timeout_o(mem_timeout_o), .lu_cnt_o(lu_cnt_o),
      .mem_cnt_o(mem_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   logic [OW-1:0] exp_q[$];
   string         tag_q[$];
   int            total = 0;
   int            bad   = 0;
   string         phase = "init";

   // Reference model: the core is idle, running, waiting on dcache, or halted.
   bit m_run, m_wait, m_halt, m_to;
   int m_wcnt, m_lu, m_mem, m_fl;

   function automatic logic [CW-1:0] sat(input int v);
      int mx;
      mx = (1 << CW) - 1;
      return (v > mx) ? CW'(mx) : CW'(v);
   endfunction

   task automatic model_reset();
      m_run = 0; m_wait = 0; m_halt = 0; m_to = 0;
      m_wcnt = 0; m_lu = 0; m_mem = 0; m_fl = 0;
   endtask

   task automatic step(input bit st, input bit mr, input int ert, input int rs, input int rt,
                       input bit br, input bit jp, input bit rq, input bit ak);
      bit ps, en, wr, fl, bb, fz, e_to, lu;
      logic [CW-1:0] c_lu, c_mem, c_fl;
      start_i = st; id_ex_memread_i = mr;
      id_ex_rt_i = AW'(ert); if_id_rs_i = AW'(rs); if_id_rt_i = AW'(rt);
      branch_taken_i = br; jump_i = jp; mem_req_i = rq; mem_ack_i = ak;
      ps = 0; en = 0; wr = 0; fl = 0; bb = 0; fz = 0;
      e_to = m_to;
`ifdef STALL_PERF_CNT_EN
      c_lu = sat(m_lu); c_mem = sat(m_mem); c_fl = sat(m_fl);
`else
      c_lu = '0; c_mem = '0; c_fl = '0;
`endif
      lu = mr && (ert != 0) && (ert == rs || ert == rt);
      if (m_halt) begin
         fz = 1; ps = 1;
      end else if (m_wait) begin
         en = 1;
         if (ak) begin
            wr = 1; m_wait = 0; m_wcnt = 0;
         end else begin
            fz = 1; ps = 1; m_mem++; m_wcnt++;
            if (m_wcnt == TO) begin
               m_halt = 1; m_to = 1; m_wait = 0;
            end
         end
      end else if (m_run) begin
         en = 1; wr = 1;
         if (rq && !ak) begin
            fz = 1; ps = 1; wr = 0; m_mem++; m_wait = 1; m_wcnt = 0;
         end else begin
            if (lu) begin
               ps = 1; wr = 0; bb = 1; m_lu++;
            end else if (br || jp) begin
               fl = 1; m_fl++;
            end
            if (!st) m_run = 0;
         end
      end else if (st) begin
         m_run = 1;
      end
      exp_q.push_back({ps, en, wr, fl, bb, fz, e_to, c_lu, c_mem, c_fl});
      tag_q.push_back(phase);
      @(posedge clk_i); #1;
   endtask

   task automatic idle_step(input bit st);
      step(st, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Reset is asserted mid-cycle so its asynchronous effect is visible before the next edge.
   task automatic do_reset();
      rst_i = 1'b0;
      model_reset();
      start_i = 0; id_ex_memread_i = 0; id_ex_rt_i = '0; if_id_rs_i = '0; if_id_rt_i = '0;
      branch_taken_i = 0; jump_i = 0; mem_req_i = 0; mem_ack_i = 0;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back('0);
         tag_q.push_back({phase, "_rst"});
         @(posedge clk_i); #1;
      end
      rst_i = 1'b1;
   endtask

   always @(negedge clk_i) begin
      if (exp_q.size() > 0) begin
         logic [OW-1:0] e, a;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = {pc_stall_o, pc_enable_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
              pipe_freeze_o, mem_timeout_o, lu_cnt_o, mem_cnt_o, flush_cnt_o};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL %s t=%0t got={stall,en,wr,fl,bb,fz,to,lu,mem,fl}=%b want=%b", t, $time, a, e);
         end
      end
   end

   initial begin
      rst_i = 1'b0;
      start_i = 0; id_ex_memread_i = 0; id_ex_rt_i = '0; if_id_rs_i = '0; if_id_rt_i = '0;
      branch_taken_i = 0; jump_i = 0; mem_req_i = 0; mem_ack_i = 0;
      @(posedge clk_i); #1;

      phase = "reset_idle";
      do_reset();
      idle_step(0); idle_step(0);
      phase = "start";
      idle_step(1); idle_step(1);

      phase = "load_use";
      step(1, 1, 5, 5, 3, 0, 0, 0, 0);
      step(1, 1, 5, 2, 5, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 5, 5, 5, 0, 0, 0, 0);

      phase = "lu_vs_branch";
      step(1, 1, 7, 7, 1, 1, 0, 0, 0);
      step(1, 0, 7, 7, 1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0);

      phase = "mem_wait";
      step(1, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 1);
      idle_step(1);
      phase = "req_ack_same";
      step(1, 0, 0, 0, 0, 0, 0, 1, 1);
      idle_step(1);

      phase = "lu_saturate";
      for (int i = 0; i < 5; i++) step(1, 1, 9, 9, 9, 0, 0, 0, 0);
      idle_step(1);

      phase = "stop_to_idle";
      idle_step(0); idle_step(0); idle_step(1);

      phase = "reset_mid_wait";
      step(1, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 0);
      do_reset();
      idle_step(0);

      phase = "timeout";
      idle_step(1);
      for (int i = 0; i < 11; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 1);
      step(1, 1, 4, 4, 4, 1, 0, 0, 0);
      do_reset();
      idle_step(0);

      phase = "random";
      for (int i = 0; i < 400; i++) begin
         if (i % 50 == 0) begin
            do_reset();
            idle_step(1);
         end
         step($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 4);
      end

      phase = "drain";
      @(posedge clk_i); #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
